// File: rtl/rc5_pkg.sv
// Shared RC5 key-schedule constants and FSM state encoding.
package rc5_pkg;
    localparam int RC5_W = 32;
    localparam int RC5_R = 12;
    localparam int RC5_T = 2 * (RC5_R + 1);
    localparam int RC5_C = 4;
    localparam logic [31:0] RC5_P = 32'hB7E15163;
    localparam logic [31:0] RC5_Q = 32'h9E3779B9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_MIX  = 2'd2,
        ST_DONE = 2'd3
    } rc5_state_t;

    function automatic int rc5_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/rc5_rotl.sv
// Combinational variable rotate-left of a W-bit word by a 5-bit amount.
module rc5_rotl #(
    parameter int W = 32
) (
    input  logic [W-1:0] data,
    input  logic [4:0]   amount,
    output logic [W-1:0] result
);
    // A shift by the full word width yields zero, so amount 0 passes data straight through.
    always_comb begin
        result = (data << amount) | (data >> (W - int'(amount)));
    end
endmodule

// File: rtl/rc5_key_schedule_ctrl.sv
// RC5 key expansion controller: fills S from P/Q, mixes it with the L words,
// then serves the finished S table to the cipher engine.
module rc5_key_schedule_ctrl
    import rc5_pkg::*;
#(
    parameter int           w = RC5_W,
    parameter int           r = RC5_R,
    parameter int           c = RC5_C,
    parameter logic [w-1:0] P = RC5_P,
    parameter logic [w-1:0] Q = RC5_Q
) (
    input  logic         clk1,
    input  logic         rst,
    input  logic         start,
    input  logic         l_wr_en,
    input  logic [1:0]   l_wr_addr,
    input  logic [w-1:0] l_wr_data,
    input  logic [4:0]   s_rd_addr,
    output logic [w-1:0] s_rd_data,
    output logic         busy,
    output logic         done,
    output logic         keys_valid
);
    localparam int t     = 2 * (r + 1);
    localparam int MIX_N = 3 * rc5_max(t, c);
    localparam int IW    = $clog2(t);
    localparam int JW    = $clog2(c);
    localparam int KW    = $clog2(MIX_N);

    localparam logic [IW-1:0] I_LAST = IW'(t - 1);
    localparam logic [JW-1:0] J_LAST = JW'(c - 1);
    localparam logic [KW-1:0] K_LAST = KW'(MIX_N - 1);
    localparam logic [4:0]    T_ADDR = 5'(t);

    rc5_state_t   state;
    logic [w-1:0] s_mem [0:t-1];
    logic [w-1:0] l_mem [0:c-1];
    logic [w-1:0] a_reg, b_reg, init_val;
    logic [IW-1:0] i_cnt;
    logic [JW-1:0] j_cnt;
    logic [KW-1:0] k_cnt;

    logic [w-1:0] s_sum, a_new, ab_sum, l_sum, b_new;
    logic         kv_next;

    always_comb begin
        s_sum = s_mem[i_cnt] + a_reg + b_reg;
    end

    rc5_rotl #(.W(w)) u_rotl_a (
        .data   (s_sum),
        .amount (5'd3),
        .result (a_new)
    );

    always_comb begin
        ab_sum = a_new + b_reg;
        l_sum  = l_mem[j_cnt] + ab_sum;
    end

    rc5_rotl #(.W(w)) u_rotl_b (
        .data   (l_sum),
        .amount (ab_sum[4:0]),
        .result (b_new)
    );

    // Register files carry no reset; only the controller state is cleared.
    always_ff @(posedge clk1) begin
        if (state == ST_IDLE && l_wr_en) begin
            l_mem[l_wr_addr] <= l_wr_data;
        end
        if (state == ST_INIT) begin
            s_mem[i_cnt] <= init_val;
        end
        if (state == ST_MIX) begin
            s_mem[i_cnt] <= a_new;
            l_mem[j_cnt] <= b_new;
        end
    end

    // Next keys_valid drives the read port so a stale table is never shown once a new run starts.
    always_comb begin
        kv_next = keys_valid;
        if (state == ST_IDLE && start) begin
            kv_next = 1'b0;
        end else if (state == ST_DONE) begin
            kv_next = 1'b1;
        end
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            s_rd_data  <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            init_val   <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            k_cnt      <= '0;
        end else begin
            done       <= 1'b0;
            keys_valid <= kv_next;
            s_rd_data  <= (kv_next && s_rd_addr < T_ADDR) ? s_mem[s_rd_addr] : '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_INIT;
                        busy     <= 1'b1;
                        i_cnt    <= '0;
                        init_val <= P;
                    end
                end
                ST_INIT: begin
                    init_val <= init_val + Q;
                    if (i_cnt == I_LAST) begin
                        state <= ST_MIX;
                        i_cnt <= '0;
                        j_cnt <= '0;
                        k_cnt <= '0;
                        a_reg <= '0;
                        b_reg <= '0;
                    end else begin
                        i_cnt <= i_cnt + IW'(1);
                    end
                end
                ST_MIX: begin
                    a_reg <= a_new;
                    b_reg <= b_new;
                    i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + IW'(1);
                    j_cnt <= (j_cnt == J_LAST) ? '0 : j_cnt + JW'(1);
                    k_cnt <= k_cnt + KW'(1);
                    if (k_cnt == K_LAST) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rc5_key_schedule_ctrl.sv
// Scoreboard bench for rc5_key_schedule_ctrl against a software RC5-32/12 key-expansion model.
module tb_rc5_key_schedule_ctrl;
    localparam int T       = 26;
    localparam int NL      = 4;
    localparam int LATENCY = 106;
    localparam logic [31:0] P_C = 32'hB7E15163;
    localparam logic [31:0] Q_C = 32'h9E3779B9;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        start;
    logic        l_wr_en;
    logic [1:0]  l_wr_addr;
    logic [31:0] l_wr_data;
    logic [4:0]  s_rd_addr;
    logic [31:0] s_rd_data;
    logic        busy;
    logic        done;
    logic        keys_valid;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc = 0;

    logic [31:0] model_l [NL];
    logic [31:0] model_s [T];
    logic        model_kv = 1'b0;

    int          done_q [$];
    logic [31:0] rd_q [$];
    logic        rd_req = 1'b0;

    rc5_key_schedule_ctrl dut (
        .clk1       (clk1),
        .rst        (rst),
        .start      (start),
        .l_wr_en    (l_wr_en),
        .l_wr_addr  (l_wr_addr),
        .l_wr_data  (l_wr_data),
        .s_rd_addr  (s_rd_addr),
        .s_rd_data  (s_rd_data),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    // Textbook RC5 key expansion with plain loops and modular arithmetic.
    task automatic compute_model();
        logic [31:0] l [NL];
        logic [31:0] a, b;
        int ii, jj;
        l = model_l;
        model_s[0] = P_C;
        for (int n = 1; n < T; n++) model_s[n] = model_s[n-1] + Q_C;
        a = 0; b = 0; ii = 0; jj = 0;
        for (int k = 0; k < 3 * T; k++) begin
            a = rotl32(model_s[ii] + a + b, 3);
            model_s[ii] = a;
            b = rotl32(l[jj] + a + b, int'((a + b) & 32'd31));
            l[jj] = b;
            ii = (ii + 1) % T;
            jj = (jj + 1) % NL;
        end
    endtask

    function automatic logic [31:0] expected_s(input int a);
        return (model_kv && a < T) ? model_s[a] : 32'd0;
    endfunction

    // Monitor: pops the scoreboard whenever done pulses or a read result is due.
    always @(posedge clk1) begin
        #1;
        if (done) begin
            if (done_q.size() == 0) begin
                check_output("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                check_output("done_latency", 32'(cyc), 32'(done_q.pop_front()));
                check_output("kv_at_done", {31'd0, keys_valid}, 32'd1);
            end
        end
        if (rd_req && rd_q.size() > 0) begin
            check_output("s_rd_data", s_rd_data, rd_q.pop_front());
        end
    end

    task automatic write_l(input int idx, input logic [31:0] d);
        @(negedge clk1);
        l_wr_en   = 1'b1;
        l_wr_addr = idx[1:0];
        l_wr_data = d;
        @(negedge clk1);
        l_wr_en   = 1'b0;
    endtask

    task automatic load_l();
        for (int n = 0; n < NL; n++) write_l(n, model_l[n]);
    endtask

    task automatic load_random_l();
        for (int n = 0; n < NL; n++) model_l[n] = $urandom;
        load_l();
    endtask

    task automatic apply_stimulus(input bit with_wr, input int idx, input logic [31:0] d);
        @(negedge clk1);
        start = 1'b1;
        if (with_wr) begin
            l_wr_en   = 1'b1;
            l_wr_addr = idx[1:0];
            l_wr_data = d;
            model_l[idx] = d;
        end
        compute_model();
        done_q.push_back(cyc + LATENCY);
        model_kv = 1'b0;
        @(negedge clk1);
        start   = 1'b0;
        l_wr_en = 1'b0;
        check_output("busy_after_start", {31'd0, busy}, 32'd1);
        check_output("kv_cleared_on_start", {31'd0, keys_valid}, 32'd0);
        check_output("rd_zero_after_start", s_rd_data, 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_q.size() > 0 && n < 300) begin
            @(negedge clk1);
            n++;
        end
        if (done_q.size() > 0) begin
            checks_total++;
            $display("[TB] FAIL done_wait: got no done within 300 cycles, expected %0d pending", done_q.size());
            done_q.delete();
        end
        model_kv = 1'b1;
        check_output("kv_level_after_done", {31'd0, keys_valid}, 32'd1);
        check_output("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic read_s(input int a);
        @(negedge clk1);
        s_rd_addr = a[4:0];
        rd_req    = 1'b1;
        rd_q.push_back(expected_s(a));
    endtask

    task automatic read_end();
        @(negedge clk1);
        rd_req = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < T; a++) read_s(a);
        read_end();
    endtask

    task automatic abort_now();
        #2 rst = 1'b0;
        #1;
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        check_output("abort_done", {31'd0, done}, 32'd0);
        check_output("abort_kv", {31'd0, keys_valid}, 32'd0);
        check_output("abort_rd", s_rd_data, 32'd0);
        done_q.delete();
        model_kv = 1'b0;
    endtask

    initial begin
        logic [127:0] key;
        int s0;
        int widx;

        rst = 1'b0; start = 1'b0; l_wr_en = 1'b0;
        l_wr_addr = '0; l_wr_data = '0; s_rd_addr = '0;
        repeat (3) @(negedge clk1);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_done", {31'd0, done}, 32'd0);
        check_output("reset_kv", {31'd0, keys_valid}, 32'd0);
        check_output("reset_rd", s_rd_data, 32'd0);
        rst = 1'b1;

        // Abort two INIT writes in: first two S words present, nothing else follows.
        for (int n = 0; n < NL; n++) model_l[n] = 32'd0;
        load_l();
        apply_stimulus(1'b0, 0, 32'd0);
        @(posedge clk1);
        @(posedge clk1);
        abort_now();
        check_output("abort_s0", dut.s_mem[0], P_C);
        check_output("abort_s1", dut.s_mem[1], P_C + Q_C);
        repeat (4) @(negedge clk1);
        rst = 1'b1;
        repeat (4) @(negedge clk1);

        // All-zero key.
        load_l();
        apply_stimulus(1'b0, 0, 32'd0);
        wait_done();
        read_all();

        // Reference 128-bit key, bytes packed little-endian into L words.
        key = 128'hFFFEEEE58684FFF05FFE493853000434;
        for (int n = 0; n < 16; n++) model_l[n/4][8*(n%4) +: 8] = key[127 - 8*n -: 8];
        load_l();
        apply_stimulus(1'b0, 0, 32'd0);
        wait_done();
        read_all();

        // Read-port boundaries.
        read_s(26);
        read_s(0);
        read_s(31);
        read_s(25);
        read_end();

        // L write during INIT and start during MIX are both ignored.
        load_random_l();
        apply_stimulus(1'b0, 0, 32'd0);
        s0 = cyc;
        repeat (2) @(negedge clk1);
        widx = $urandom_range(0, NL - 1);
        l_wr_en   = 1'b1;
        l_wr_addr = widx[1:0];
        l_wr_data = ~model_l[widx];
        @(negedge clk1);
        l_wr_en = 1'b0;
        read_s(7);
        read_end();
        while (cyc < s0 + 26 + 10) @(negedge clk1);
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        wait_done();
        read_all();

        // Abort mid-MIX, then a clean rerun.
        load_random_l();
        apply_stimulus(1'b0, 0, 32'd0);
        s0 = cyc;
        while (cyc < s0 + 26 + 40) @(negedge clk1);
        @(posedge clk1);
        abort_now();
        repeat (3) @(negedge clk1);
        rst = 1'b1;
        load_random_l();
        apply_stimulus(1'b0, 0, 32'd0);
        wait_done();
        read_all();

        // L write on the same edge as start lands before the schedule uses it.
        for (int run = 0; run < 3; run++) begin
            load_random_l();
            apply_stimulus(1'b1, $urandom_range(0, NL - 1), $urandom);
            wait_done();
            for (int n = 0; n < 6; n++) read_s($urandom_range(0, 31));
            read_end();
        end

        repeat (5) @(negedge clk1);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/rc5_key_schedule_ctrl.md
RC5_KEY_SCHEDULE_CTRL -- requirements
Module: rc5_key_schedule_ctrl

Interface
REQ-001 SHALL have parameter w, default 32: word width in bits.
REQ-002 SHALL have parameter r, default 12: round count; t = 2*(r+1) = 26 S words.
REQ-003 SHALL have parameter c, default 4: L word count (key bytes / 4).
REQ-004 SHALL have parameters P, default 32'hB7E15163, and Q, default 32'h9E3779B9: magic constants.
REQ-005 SHALL have port clk1  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1  one-cycle request to run key expansion.
REQ-008 SHALL have port l_wr_en  in  1  write strobe for an L word.
REQ-009 SHALL have port l_wr_addr  in  2  L word index 0..c-1.
REQ-010 SHALL have port l_wr_data  in  w  L word from the byte-to-word converter.
REQ-011 SHALL have port s_rd_addr  in  5  S word index for the cipher engine.
REQ-012 SHALL have port s_rd_data  out  w  S word, registered.
REQ-013 SHALL have port busy  out  1  high in INIT and MIX.
REQ-014 SHALL have port done  out  1  one-cycle pulse at schedule completion.
REQ-015 SHALL have port keys_valid  out  1  S table valid; level.

Function
REQ-016 SHALL implement FSM states IDLE, INIT, MIX, DONE.
REQ-017 IDLE->INIT SHALL occur on the edge sampling start=1; keys_valid cleared on the same edge.
REQ-018 INIT SHALL write S[i] = P + i*Q (mod 2^w), one word per cycle, i = 0..t-1: 26 cycles, then ->MIX.
REQ-019 MIX entry SHALL clear A, B, i, j, k.
REQ-020 Each MIX cycle SHALL compute A' = rotl(S[i]+A+B, 3), then B' = rotl(L[j]+A'+B, (A'+B)[4:0]); write S[i]=A', L[j]=B'.
REQ-021 MIX SHALL run 3*max(t,c) = 78 cycles; i wraps 25->0, j wraps 3->0, k counts 0..77.
REQ-022 After k=77, MIX->DONE; DONE SHALL assert done for exactly one cycle, set keys_valid, then ->IDLE.
REQ-023 Latency: done SHALL be high in the 106th cycle after the edge sampling start.
REQ-024 start while busy or in DONE SHALL be ignored.
REQ-025 l_wr_en SHALL write L only in IDLE; writes in other states SHALL be dropped.
REQ-026 l_wr_en and start sampled on the same edge: the write SHALL take effect before INIT begins.
REQ-027 s_rd_data SHALL equal S[s_rd_addr] one cycle after the address; addr >= t SHALL return 0.
REQ-028 While keys_valid=0, s_rd_data SHALL be 0.
REQ-029 L SHALL be overwritten by MIX; the converter must reload L before the next start.
REQ-030 All additions SHALL be modulo 2^w; rotation amount SHALL be the low 5 bits only.

Reset
REQ-031 rst=0 SHALL immediately force IDLE; busy=0, done=0, keys_valid=0, s_rd_data=0.
REQ-032 rst SHALL clear A, B, i, j, k; S and L contents need not be cleared.
REQ-033 rst asserted mid-INIT or mid-MIX SHALL abort; no done pulse SHALL follow.

Structure
REQ-034 w, r, t, c, P, Q and the FSM state encoding SHALL live in shared package rc5_pkg.
REQ-035 Variable rotate-left SHALL be sub-module rc5_rotl (combinational, w-bit data, 5-bit amount).
REQ-036 S (26 x w) and L (4 x w) SHALL be register files internal to this block.

Verification
REQ-037 Reset, start, abort at INIT cycle 2 (rst low) -> S[0]=32'hB7E15163, S[1]=32'h5618CB1C written; no done; keys_valid=0.
REQ-038 L = {0,0,0,0}, start -> done exactly 106 cycles later; all 26 S words match the software RC5-32/12/16 model.
REQ-039 L = key 128'hFFFEEEE58684FFF05FFE493853000434 as 4 words, start -> S matches the model; keys_valid=1 after done.
REQ-040 start pulsed at MIX cycle 10, l_wr_en at INIT cycle 3 -> both ignored; done timing unchanged; L unchanged by the write.
REQ-041 rst=0 at MIX cycle 40 -> busy=0 immediately; s_rd_data=0; new start -> full 106-cycle run, correct S.
REQ-042 After done, s_rd_addr=26 -> s_rd_data=0 next cycle; s_rd_addr=0 -> model S[0] next cycle.
